status_array_updater: RTL and testbench
=======================================

Name: status_array_updater

Overview:
- Initiator side of the status array interface: drives the read port, consumes read responses, and issues masked write-backs.
- Performs per-block status maintenance as read-modify-write sequences:
  - TOUCH: LRU age update on a hit.
  - FILL: mark a block valid and youngest.
  - INVAL: clear a single block.
  - FLUSH: zero every row.
- Sits between the cache controller and the status array wrapper. Only one operation is outstanding at a time.

Parameters:
- ADDR_WIDTH, 6, row address width; 2^ADDR_WIDTH rows.
- NUM_BLOCKS, 4, blocks (ways) per row.
- AGE_WIDTH, 2, LRU age bits per block.
- BLK_IDX_WIDTH, 2, block index width; equals clog2(NUM_BLOCKS).
- TAG_WIDTH, 1, read-request tag width.
- BLOCK_STAT_WIDTH, AGE_WIDTH+1, status bits per block.
- ROW_WIDTH, NUM_BLOCKS*BLOCK_STAT_WIDTH, row width.

Ports:
- clk  in  1  clock.
- srst_n  in  1  reset, synchronous, active-low.
- i_halt  in  1  freezes all state and outputs while high.
- i_req_op  in  2  operation: 00 TOUCH, 01 FILL, 10 INVAL, 11 FLUSH.
- i_req_addr  in  ADDR_WIDTH  target row.
- i_req_block  in  BLK_IDX_WIDTH  target block within the row.
- i_req_valid  in  1  request valid.
- o_req_ready  out  1  request accepted when i_req_valid and o_req_ready are both high.
- o_done  out  1  one-cycle pulse when the operation's final write is issued.
- o_sa_tag  out  TAG_WIDTH  read request tag.
- o_sa_r_addr  out  ADDR_WIDTH  read address.
- o_sa_r_valid  out  1  read request valid.
- i_sa_tag  in  TAG_WIDTH  response tag.
- i_sa_data  in  ROW_WIDTH  response row.
- i_sa_valid  in  1  response valid.
- i_sa_ready  in  1  status array ready, for both read and write.
- o_sa_w_addr  out  ADDR_WIDTH  write address.
- o_sa_w_data  out  ROW_WIDTH  write row.
- o_sa_w_wmask  out  NUM_BLOCKS  per-block write enable.
- o_sa_w_valid  out  1  write valid.

Behaviour:
- Row layout: block k occupies bits [k*BSW+BSW-1 : k*BSW], where BSW = BLOCK_STAT_WIDTH. The MSB is the valid bit; the low AGE_WIDTH bits are the age.
- Reset: when srst_n is low at a clk edge, state goes to IDLE. All o_sa_* valids, o_done and the tag counter go to 0. o_req_ready reads 1 in IDLE. All address and data outputs go to 0.
- Reset has priority over i_halt.
- i_halt high: all registers hold and outputs hold their values. No request is accepted, since o_req_ready is forced to 0. Responses are not consumed.
- FSM states: IDLE, RD_REQ, RD_WAIT, WRITE, FLUSH.
- IDLE: o_req_ready=1. On acceptance, op, addr and block are latched.
  - TOUCH/FILL go to RD_REQ.
  - INVAL goes to WRITE.
  - FLUSH goes to FLUSH with the row counter at 0.
- RD_REQ: o_sa_r_valid=1, o_sa_r_addr=the latched address, o_sa_tag=the tag counter. When i_sa_ready=1, the tag counter is incremented modulo 2^TAG_WIDTH and the state moves to RD_WAIT.
- RD_WAIT: the block waits for i_sa_valid with i_sa_tag equal to the issued tag. Responses whose tag does not match are ignored. On a match, i_sa_data is latched and the state moves to WRITE. There is no timeout.
- WRITE: o_sa_w_valid=1. On i_sa_ready=1, o_done pulses and the state returns to IDLE. The write data per op is:
  - INVAL: o_sa_w_data=0; the wmask is one-hot on the target block.
  - TOUCH: old_age = age of the target block.
    - Target block: valid=1, age=0.
    - Every other valid block with age < old_age: age+1, saturating at 2^AGE_WIDTH-1.
    - Invalid blocks, and blocks with age >= old_age, are unchanged.
    - wmask is all ones.
  - FILL: same as TOUCH, except old_age = 2^AGE_WIDTH-1 when the target block was invalid.
  - A TOUCH to an invalid block is treated as FILL.
- FLUSH: o_sa_w_valid=1, o_sa_w_data=0, wmask all ones, o_sa_w_addr=the row counter.
  - The counter increments on each cycle with i_sa_ready=1.
  - When the write to the last row (2^ADDR_WIDTH-1) is accepted, o_done pulses and the state moves to IDLE. There is no wrap.
  - Latency is 2^ADDR_WIDTH accepted cycles.
- Ordering: the minimum latency is 1 cycle from acceptance to the read request. The next request is accepted no earlier than the cycle after the write is accepted, so a back-to-back read-after-write to the same row always sees the new data.
- Reset mid-operation abandons the operation with no o_done. A stale response arriving after reset is ignored, because the block is not in RD_WAIT.

Decomposition:
- Shared package/header: op encodings (OP_TOUCH, OP_FILL, OP_INVAL, OP_FLUSH), FSM state encodings, BLOCK_STAT_WIDTH, and the row-layout field offsets.
- ADDR_WIDTH and NUM_BLOCKS come from the existing status array parameter header.
- One sub-module: status_row_lru_update. It is purely combinational: inputs are the row, block index and a fill flag; outputs are the next row and wmask. It carries the age/valid arithmetic.

Test Plan:
1. Reset with srst_n=0 for 2 cycles -> o_req_ready=1, all o_sa_* valids=0, o_done=0.
2. FILL addr 5 block 2; response row 12'h000 -> write addr 5, data 12'h100 (block 2 valid, age 0), wmask 4'hF, o_done pulse.
3. TOUCH addr 5 block 1; response has blocks 0..3 valid with ages 3,2,0,1 -> written ages 3,0,1,2, all valid.
4. INVAL addr 9 block 3 -> no read issued; write data 0, wmask 4'b1000, o_done one cycle after the write handshake.
5. FLUSH with i_sa_ready toggling -> 64 writes, addresses 0..63 in order, o_done exactly once on the row 63 write.
6. A mismatched-tag response in RD_WAIT is ignored; i_halt high for 3 cycles in RD_WAIT freezes all outputs; srst_n=0 mid-FLUSH -> IDLE, no o_done.

Source files
------------

// File: rtl/status_array_updater_pkg.sv
// Shared encodings and default geometry for the status array updater.
// Rows are NUM_BLOCKS fields of {valid, age}; the valid bit sits directly above the age.
package status_array_updater_pkg;

  localparam int SA_ADDR_WIDTH    = 6;
  localparam int SA_NUM_BLOCKS    = 4;
  localparam int SA_AGE_WIDTH     = 2;
  localparam int SA_BLK_IDX_WIDTH = $clog2(SA_NUM_BLOCKS);
  localparam int SA_TAG_WIDTH     = 1;
  localparam int BLOCK_STAT_WIDTH = SA_AGE_WIDTH + 1;

  // Field offsets inside one block's status slice
  localparam int AGE_OFS = 0;

  typedef enum logic [1:0] {
    OP_TOUCH = 2'b00,
    OP_FILL  = 2'b01,
    OP_INVAL = 2'b10,
    OP_FLUSH = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_WRITE,
    ST_FLUSH
  } state_e;

endpackage

// File: rtl/status_row_lru_update.sv
// Combinational LRU age/valid update of one status row for a hit or fill on a target block.
// Blocks younger than the target's old age get one step older; the target becomes youngest.
module status_row_lru_update
  import status_array_updater_pkg::*;
#(
  parameter int NUM_BLOCKS    = SA_NUM_BLOCKS,
  parameter int AGE_WIDTH     = SA_AGE_WIDTH,
  parameter int BLK_IDX_WIDTH = SA_BLK_IDX_WIDTH,
  localparam int BSW          = AGE_WIDTH + 1,
  localparam int ROW_WIDTH    = NUM_BLOCKS * BSW
) (
  input  logic [ROW_WIDTH-1:0]     row,
  input  logic [BLK_IDX_WIDTH-1:0] blk,
  input  logic                     fill,
  output logic [ROW_WIDTH-1:0]     row_next,
  output logic [NUM_BLOCKS-1:0]    wmask
);

  localparam int VALID_BIT = AGE_OFS + AGE_WIDTH;
  localparam logic [AGE_WIDTH-1:0] AGE_MAX = '1;

  logic [NUM_BLOCKS-1:0] valid;
  logic [AGE_WIDTH-1:0]  age [NUM_BLOCKS];
  logic [AGE_WIDTH-1:0]  old_age;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BLOCKS; gi++) begin : g_unpack
      assign valid[gi] = row[gi*BSW + VALID_BIT];
      assign age[gi]   = row[gi*BSW + AGE_OFS +: AGE_WIDTH];
    end
  endgenerate

  // An invalid target is a fill: every other valid block ages
  assign old_age = (fill || !valid[blk]) ? AGE_MAX : age[blk];

  generate
    for (gi = 0; gi < NUM_BLOCKS; gi++) begin : g_update
      logic                 is_tgt;
      logic                 bump;
      logic                 valid_out;
      logic [AGE_WIDTH-1:0] age_out;

      assign is_tgt    = (blk == BLK_IDX_WIDTH'(gi));
      assign bump      = valid[gi] && (age[gi] < old_age) && (age[gi] != AGE_MAX);
      assign valid_out = is_tgt | valid[gi];
      assign age_out   = is_tgt ? '0 : (bump ? age[gi] + 1'b1 : age[gi]);

      assign row_next[gi*BSW + VALID_BIT]             = valid_out;
      assign row_next[gi*BSW + AGE_OFS +: AGE_WIDTH]  = age_out;
    end
  endgenerate

  assign wmask = '1;

endmodule

// File: rtl/status_array_updater.sv
// Status array initiator: runs TOUCH/FILL/INVAL/FLUSH as read-modify-write sequences,
// one operation outstanding at a time, with masked write-backs.
module status_array_updater
  import status_array_updater_pkg::*;
#(
  parameter int ADDR_WIDTH       = SA_ADDR_WIDTH,
  parameter int NUM_BLOCKS       = SA_NUM_BLOCKS,
  parameter int AGE_WIDTH        = SA_AGE_WIDTH,
  parameter int BLK_IDX_WIDTH    = SA_BLK_IDX_WIDTH,
  parameter int TAG_WIDTH        = SA_TAG_WIDTH,
  localparam int BLOCK_STAT_W    = AGE_WIDTH + 1,
  localparam int ROW_WIDTH       = NUM_BLOCKS * BLOCK_STAT_W
) (
  input  logic                     clk,
  input  logic                     srst_n,
  input  logic                     i_halt,
  input  logic [1:0]               i_req_op,
  input  logic [ADDR_WIDTH-1:0]    i_req_addr,
  input  logic [BLK_IDX_WIDTH-1:0] i_req_block,
  input  logic                     i_req_valid,
  output logic                     o_req_ready,
  output logic                     o_done,
  output logic [TAG_WIDTH-1:0]     o_sa_tag,
  output logic [ADDR_WIDTH-1:0]    o_sa_r_addr,
  output logic                     o_sa_r_valid,
  input  logic [TAG_WIDTH-1:0]     i_sa_tag,
  input  logic [ROW_WIDTH-1:0]     i_sa_data,
  input  logic                     i_sa_valid,
  input  logic                     i_sa_ready,
  output logic [ADDR_WIDTH-1:0]    o_sa_w_addr,
  output logic [ROW_WIDTH-1:0]     o_sa_w_data,
  output logic [NUM_BLOCKS-1:0]    o_sa_w_wmask,
  output logic                     o_sa_w_valid
);

  localparam logic [ADDR_WIDTH-1:0] ROW_LAST = '1;

  state_e                   state_reg, state_next;
  op_e                      op_reg, op_next;
  logic [ADDR_WIDTH-1:0]    addr_reg, addr_next;
  logic [ADDR_WIDTH-1:0]    row_cnt_reg, row_cnt_next;
  logic [BLK_IDX_WIDTH-1:0] blk_reg, blk_next;
  logic [TAG_WIDTH-1:0]     tag_cnt_reg, tag_cnt_next;
  logic [TAG_WIDTH-1:0]     issued_tag_reg, issued_tag_next;
  logic [ROW_WIDTH-1:0]     rd_row_reg, rd_row_next;
  logic                     done_reg, done_next;

  logic [ROW_WIDTH-1:0]     lru_row;
  logic [NUM_BLOCKS-1:0]    lru_mask;
  logic [NUM_BLOCKS-1:0]    inval_mask;

  status_row_lru_update #(
    .NUM_BLOCKS    (NUM_BLOCKS),
    .AGE_WIDTH     (AGE_WIDTH),
    .BLK_IDX_WIDTH (BLK_IDX_WIDTH)
  ) u_lru (
    .row      (rd_row_reg),
    .blk      (blk_reg),
    .fill     (op_reg == OP_FILL),
    .row_next (lru_row),
    .wmask    (lru_mask)
  );

  assign inval_mask  = NUM_BLOCKS'(1) << blk_reg;
  assign o_done      = done_reg;
  assign o_sa_r_addr = addr_reg;
  assign o_sa_tag    = tag_cnt_reg;

  always_ff @(posedge clk) begin
    if (!srst_n) begin
      state_reg      <= ST_IDLE;
      op_reg         <= OP_TOUCH;
      addr_reg       <= '0;
      row_cnt_reg    <= '0;
      blk_reg        <= '0;
      tag_cnt_reg    <= '0;
      issued_tag_reg <= '0;
      rd_row_reg     <= '0;
      done_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      op_reg         <= op_next;
      addr_reg       <= addr_next;
      row_cnt_reg    <= row_cnt_next;
      blk_reg        <= blk_next;
      tag_cnt_reg    <= tag_cnt_next;
      issued_tag_reg <= issued_tag_next;
      rd_row_reg     <= rd_row_next;
      done_reg       <= done_next;
    end
  end

  // Halt blocks every transition; outputs decode from held state so they freeze too
  always_comb begin
    state_next      = state_reg;
    op_next         = op_reg;
    addr_next       = addr_reg;
    row_cnt_next    = row_cnt_reg;
    blk_next        = blk_reg;
    tag_cnt_next    = tag_cnt_reg;
    issued_tag_next = issued_tag_reg;
    rd_row_next     = rd_row_reg;
    done_next       = i_halt ? done_reg : 1'b0;
    o_req_ready     = 1'b0;
    o_sa_r_valid    = 1'b0;
    o_sa_w_valid    = 1'b0;
    o_sa_w_addr     = addr_reg;
    o_sa_w_data     = '0;
    o_sa_w_wmask    = '0;

    case (state_reg)
      ST_IDLE: begin
        o_req_ready = !i_halt;
        if (i_req_valid && !i_halt) begin
          op_next   = op_e'(i_req_op);
          addr_next = i_req_addr;
          blk_next  = i_req_block;
          case (op_e'(i_req_op))
            OP_TOUCH, OP_FILL: state_next = ST_RD_REQ;
            OP_INVAL:          state_next = ST_WRITE;
            default: begin
              state_next   = ST_FLUSH;
              row_cnt_next = '0;
            end
          endcase
        end
      end
      ST_RD_REQ: begin
        o_sa_r_valid = 1'b1;
        if (i_sa_ready && !i_halt) begin
          tag_cnt_next    = tag_cnt_reg + 1'b1;
          issued_tag_next = tag_cnt_reg;
          state_next      = ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: begin
        if (i_sa_valid && (i_sa_tag == issued_tag_reg) && !i_halt) begin
          rd_row_next = i_sa_data;
          state_next  = ST_WRITE;
        end
      end
      ST_WRITE: begin
        o_sa_w_valid = 1'b1;
        if (op_reg == OP_INVAL) begin
          o_sa_w_wmask = inval_mask;
        end else begin
          o_sa_w_data  = lru_row;
          o_sa_w_wmask = lru_mask;
        end
        if (i_sa_ready && !i_halt) begin
          done_next  = 1'b1;
          state_next = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        o_sa_w_valid = 1'b1;
        o_sa_w_addr  = row_cnt_reg;
        o_sa_w_wmask = '1;
        if (i_sa_ready && !i_halt) begin
          if (row_cnt_reg == ROW_LAST) begin
            done_next  = 1'b1;
            state_next = ST_IDLE;
          end else begin
            row_cnt_next = row_cnt_reg + 1'b1;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_status_array_updater.sv
// Randomized bench: models the status array memory and checks every write-back against
// LRU rules evaluated on plain integer ages.
module tb_status_array_updater;
  import status_array_updater_pkg::*;

  localparam int AW   = 6;
  localparam int NB   = 4;
  localparam int AGW  = 2;
  localparam int BW   = 2;
  localparam int TW   = 1;
  localparam int BSW  = AGW + 1;
  localparam int RW   = NB * BSW;
  localparam int AMAX = (1 << AGW) - 1;
  localparam int ROWS = 1 << AW;

  logic          clk = 1'b0;
  logic          srst_n;
  logic          i_halt;
  logic [1:0]    i_req_op;
  logic [AW-1:0] i_req_addr;
  logic [BW-1:0] i_req_block;
  logic          i_req_valid;
  logic          o_req_ready;
  logic          o_done;
  logic [TW-1:0] o_sa_tag;
  logic [AW-1:0] o_sa_r_addr;
  logic          o_sa_r_valid;
  logic [TW-1:0] i_sa_tag;
  logic [RW-1:0] i_sa_data;
  logic          i_sa_valid;
  logic          i_sa_ready;
  logic [AW-1:0] o_sa_w_addr;
  logic [RW-1:0] o_sa_w_data;
  logic [NB-1:0] o_sa_w_wmask;
  logic          o_sa_w_valid;

  logic [RW-1:0] mem [ROWS];
  logic [TW-1:0] tag_model;
  int            n_vec = 0;
  int            n_bad = 0;

  always #5 clk = ~clk;

  status_array_updater dut (
    .clk          (clk),
    .srst_n       (srst_n),
    .i_halt       (i_halt),
    .i_req_op     (i_req_op),
    .i_req_addr   (i_req_addr),
    .i_req_block  (i_req_block),
    .i_req_valid  (i_req_valid),
    .o_req_ready  (o_req_ready),
    .o_done       (o_done),
    .o_sa_tag     (o_sa_tag),
    .o_sa_r_addr  (o_sa_r_addr),
    .o_sa_r_valid (o_sa_r_valid),
    .i_sa_tag     (i_sa_tag),
    .i_sa_data    (i_sa_data),
    .i_sa_valid   (i_sa_valid),
    .i_sa_ready   (i_sa_ready),
    .o_sa_w_addr  (o_sa_w_addr),
    .o_sa_w_data  (o_sa_w_data),
    .o_sa_w_wmask (o_sa_w_wmask),
    .o_sa_w_valid (o_sa_w_valid)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected row after a hit/fill on blk
  function automatic logic [RW-1:0] ref_row(input logic [RW-1:0] row, input int blk, input bit fill);
    int v[NB];
    int a[NB];
    int old;
    logic [RW-1:0] r;
    r = '0;
    for (int k = 0; k < NB; k++) begin
      v[k] = int'(row[k*BSW+AGW]);
      a[k] = int'(row[k*BSW +: AGW]);
    end
    old = (fill || v[blk] == 0) ? AMAX : a[blk];
    for (int k = 0; k < NB; k++) begin
      if (k == blk) begin
        v[k] = 1;
        a[k] = 0;
      end else if (v[k] != 0 && a[k] < old) begin
        a[k] = (a[k] + 1 > AMAX) ? AMAX : a[k] + 1;
      end
      r[k*BSW +: BSW] = BSW'(v[k] * (AMAX + 1) + a[k]);
    end
    return r;
  endfunction

  task automatic run_op(input logic [1:0] op, input int addr, input int blk);
    int reads = 0;
    int writes = 0;
    int flush_row = 0;
    int delay = -1;
    bit done_seen = 0;
    bit done_due = 0;
    bit is_rd = (op == OP_TOUCH) || (op == OP_FILL);
    logic [TW-1:0] rtag = '0;
    logic [RW-1:0] exp_data;
    logic [NB-1:0] exp_mask;
    int exp_addr;
    bit final_wr;

    i_req_op    = op;
    i_req_addr  = AW'(addr);
    i_req_block = BW'(blk);
    i_req_valid = 1'b1;
    chk("req_ready", 32'(o_req_ready), 32'd1);
    step();
    i_req_valid = 1'b0;
    if (is_rd) chk("rd_latency", 32'(o_sa_r_valid), 32'd1);

    for (int cyc = 0; cyc < 400 && !done_seen; cyc++) begin
      chk("done", 32'(o_done), 32'(done_due));
      if (o_done) done_seen = 1;
      done_due   = 0;
      i_sa_valid = 1'b0;
      i_sa_ready = 1'($urandom_range(0, 1));
      if (delay > 0) begin
        delay--;
        if ($urandom_range(0, 2) == 0) begin
          i_sa_valid = 1'b1;
          i_sa_tag   = ~rtag;
          i_sa_data  = RW'($urandom);
        end
      end else if (delay == 0) begin
        i_sa_valid = 1'b1;
        i_sa_tag   = rtag;
        i_sa_data  = mem[addr];
        delay      = -1;
      end
      if (o_sa_r_valid && i_sa_ready) begin
        reads++;
        chk("rd_addr", 32'(o_sa_r_addr), 32'(addr));
        chk("rd_tag", 32'(o_sa_tag), 32'(tag_model));
        rtag      = tag_model;
        tag_model = tag_model + 1'b1;
        delay     = $urandom_range(0, 3);
      end
      if (o_sa_w_valid && i_sa_ready) begin
        writes++;
        final_wr = 0;
        if (op == OP_FLUSH) begin
          exp_addr = flush_row;
          exp_data = '0;
          exp_mask = '1;
          final_wr = (flush_row == ROWS - 1);
          flush_row++;
        end else begin
          exp_addr = addr;
          final_wr = 1;
          if (op == OP_INVAL) begin
            exp_data = '0;
            exp_mask = NB'(1 << blk);
          end else begin
            exp_data = ref_row(mem[addr], blk, op == OP_FILL);
            exp_mask = '1;
          end
        end
        chk("wr_addr", 32'(o_sa_w_addr), 32'(exp_addr));
        chk("wr_data", 32'(o_sa_w_data), 32'(exp_data));
        chk("wr_mask", 32'(o_sa_w_wmask), 32'(exp_mask));
        for (int k = 0; k < NB; k++)
          if (o_sa_w_wmask[k]) mem[o_sa_w_addr][k*BSW +: BSW] = o_sa_w_data[k*BSW +: BSW];
        done_due = final_wr;
      end
      step();
    end
    chk("done_seen", 32'(done_seen), 32'd1);
    chk("reads", 32'(reads), is_rd ? 32'd1 : 32'd0);
    chk("writes", 32'(writes), (op == OP_FLUSH) ? 32'(ROWS) : 32'd1);
    i_sa_valid = 1'b0;
    i_sa_ready = 1'b0;
  endtask

  initial begin
    logic [TW-1:0] t6_tag;
    logic [1:0]    rop;

    srst_n      = 1'b0;
    i_halt      = 1'b0;
    i_req_op    = '0;
    i_req_addr  = '0;
    i_req_block = '0;
    i_req_valid = 1'b0;
    i_sa_tag    = '0;
    i_sa_data   = '0;
    i_sa_valid  = 1'b0;
    i_sa_ready  = 1'b0;
    tag_model   = '0;
    for (int r = 0; r < ROWS; r++) mem[r] = RW'($urandom);

    step();
    step();
    chk("rst_ready", 32'(o_req_ready), 32'd1);
    chk("rst_rvalid", 32'(o_sa_r_valid), 32'd0);
    chk("rst_wvalid", 32'(o_sa_w_valid), 32'd0);
    chk("rst_done", 32'(o_done), 32'd0);
    chk("rst_tag", 32'(o_sa_tag), 32'd0);
    chk("rst_waddr", 32'(o_sa_w_addr), 32'd0);
    chk("rst_wdata", 32'(o_sa_w_data), 32'd0);
    srst_n = 1'b1;
    step();

    mem[5] = 12'h000;
    run_op(OP_FILL, 5, 2);
    chk("fill_row5", 32'(mem[5]), 32'h100);
    mem[5] = 12'hB37;
    run_op(OP_TOUCH, 5, 1);
    chk("touch_row5", 32'(mem[5]), 32'hD67);
    run_op(OP_INVAL, 9, 3);
    chk("inval_row9_b3", 32'(mem[9][11:9]), 32'd0);
    run_op(OP_FLUSH, 0, 0);

    for (int n = 0; n < 120; n++) begin
      rop = ($urandom_range(0, 15) == 0) ? OP_FLUSH : 2'($urandom_range(0, 2));
      run_op(rop, $urandom_range(0, ROWS - 1), $urandom_range(0, NB - 1));
    end

    // Wrong-tag response, then halt in RD_WAIT with the right response pending
    mem[7] = 12'hB37;
    i_req_op = OP_TOUCH; i_req_addr = 7; i_req_block = 1; i_req_valid = 1'b1;
    step();
    i_req_valid = 1'b0;
    chk("t6_rvalid", 32'(o_sa_r_valid), 32'd1);
    chk("t6_tag", 32'(o_sa_tag), 32'(tag_model));
    t6_tag = tag_model;
    i_sa_ready = 1'b1;
    step();
    i_sa_ready = 1'b0;
    tag_model  = tag_model + 1'b1;
    chk("t6_rvalid_drop", 32'(o_sa_r_valid), 32'd0);
    i_sa_valid = 1'b1; i_sa_tag = ~t6_tag; i_sa_data = 12'hFFF;
    step();
    i_sa_valid = 1'b0;
    step();
    chk("t6_badtag_ignored", 32'(o_sa_w_valid), 32'd0);
    i_halt = 1'b1; i_sa_valid = 1'b1; i_sa_tag = t6_tag; i_sa_data = mem[7];
    for (int h = 0; h < 3; h++) begin
      step();
      chk("t6_halt_wvalid", 32'(o_sa_w_valid), 32'd0);
      chk("t6_halt_rvalid", 32'(o_sa_r_valid), 32'd0);
      chk("t6_halt_ready", 32'(o_req_ready), 32'd0);
      chk("t6_halt_done", 32'(o_done), 32'd0);
      chk("t6_halt_raddr", 32'(o_sa_r_addr), 32'd7);
      chk("t6_halt_tag", 32'(o_sa_tag), 32'(tag_model));
    end
    i_halt = 1'b0;
    step();
    i_sa_valid = 1'b0;
    chk("t6_wvalid", 32'(o_sa_w_valid), 32'd1);
    chk("t6_waddr", 32'(o_sa_w_addr), 32'd7);
    chk("t6_wdata", 32'(o_sa_w_data), 32'(ref_row(12'hB37, 1, 0)));
    chk("t6_wmask", 32'(o_sa_w_wmask), 32'hF);
    mem[7] = o_sa_w_data;
    i_sa_ready = 1'b1;
    step();
    i_sa_ready = 1'b0;
    chk("t6_done", 32'(o_done), 32'd1);
    step();
    chk("t6_done_pulse", 32'(o_done), 32'd0);

    // Reset in the middle of a flush
    i_req_op = OP_FLUSH; i_req_valid = 1'b1;
    step();
    i_req_valid = 1'b0;
    i_sa_ready  = 1'b1;
    for (int r = 0; r < 10; r++) begin
      chk("t6_flush_addr", 32'(o_sa_w_addr), 32'(r));
      mem[r] = '0;
      step();
    end
    i_sa_ready = 1'b0;
    srst_n = 1'b0;
    step();
    srst_n = 1'b1;
    tag_model = '0;
    chk("mid_rst_ready", 32'(o_req_ready), 32'd1);
    chk("mid_rst_wvalid", 32'(o_sa_w_valid), 32'd0);
    chk("mid_rst_done", 32'(o_done), 32'd0);
    chk("mid_rst_waddr", 32'(o_sa_w_addr), 32'd0);
    chk("mid_rst_tag", 32'(o_sa_tag), 32'd0);
    i_sa_valid = 1'b1; i_sa_tag = '0; i_sa_data = 12'hFFF;
    step();
    i_sa_valid = 1'b0;
    chk("stale_rsp_wvalid", 32'(o_sa_w_valid), 32'd0);
    chk("stale_rsp_done", 32'(o_done), 32'd0);
    step();
    chk("stale_rsp_done2", 32'(o_done), 32'd0);

    for (int n = 0; n < 10; n++)
      run_op(2'($urandom_range(0, 2)), $urandom_range(0, ROWS - 1), $urandom_range(0, NB - 1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
